// File: rtl/mipi_csi_tx_lane_distributor.sv
// mipi_csi_tx_lane_distributor: frames packet words onto CSI-2 HS lanes (preamble, sync, data, trail)
// Optional per-lane output skew is compiled in with MIPI_TX_LANE_SKEW_EN.
module mipi_csi_tx_lane_distributor #(
    parameter int MIPI_GEAR       = 16,
    parameter int MIPI_LANES      = 4,
    parameter int PREAMBLE_CYCLES = 4,
    parameter int TRAIL_CYCLES    = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [MIPI_GEAR*MIPI_LANES-1:0]  data_i,
    input  logic                             data_valid_i,
    input  logic                             data_last_i,
    input  logic [MIPI_LANES-1:0]            data_keep_i,
    output logic                             data_ready_o,
    input  logic [3*MIPI_LANES-1:0]          lane_skew_i,
    output logic [MIPI_GEAR*MIPI_LANES-1:0]  lane_byte_o,
    output logic [MIPI_LANES-1:0]            lane_valid_o,
    output logic [MIPI_LANES-1:0]            hs_active_o,
    output logic                             underrun_o
);
    localparam int G = MIPI_GEAR;
    localparam int L = MIPI_LANES;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, TRAIL, DRAIN} state_t;
    state_t state;
    logic [3:0] pre_cnt;
    logic [2:0] trail_cnt [L];
    logic [L-1:0] last_msb, trail_done, keep, r_valid, r_hs;
    logic [G*L-1:0] r_byte;
    logic [G-1:0] sync_word;
    logic drain_busy;
    assign sync_word = G'(16'hB800);
    assign keep = (data_keep_i == '0) ? '1 : data_keep_i;
    always_comb begin
        trail_done = '0;
        for (int n = 0; n < L; n++) trail_done[n] = trail_cnt[n] >= 3'(TRAIL_CYCLES);
    end
`ifdef MIPI_TX_LANE_SKEW_EN
    localparam state_t TRAIL_NEXT = DRAIN;
    logic [2:0] skew [L];
    logic [G-1:0] sh_byte [L][7];
    logic [6:0] sh_valid [L];
    logic [6:0] sh_hs [L];
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int n = 0; n < L; n++) begin
                skew[n] <= '0;
                sh_valid[n] <= '0;
                sh_hs[n] <= '0;
                for (int k = 0; k < 7; k++) sh_byte[n][k] <= '0;
            end
        end else begin
            for (int n = 0; n < L; n++) begin
                if (state == IDLE) skew[n] <= lane_skew_i[3*n +: 3];
                sh_valid[n] <= {sh_valid[n][5:0], r_valid[n]};
                sh_hs[n] <= {sh_hs[n][5:0], r_hs[n]};
                sh_byte[n][0] <= r_byte[n*G +: G];
                for (int k = 1; k < 7; k++) sh_byte[n][k] <= sh_byte[n][k-1];
            end
        end
    end
    // a lane's pipeline counts as busy only over the stages its skew actually taps
    always_comb begin
        lane_byte_o = r_byte;
        lane_valid_o = r_valid;
        hs_active_o = r_hs;
        drain_busy = 1'b0;
        for (int n = 0; n < L; n++) begin
            if (skew[n] != 3'd0) begin
                lane_byte_o[n*G +: G] = sh_byte[n][skew[n] - 3'd1];
                lane_valid_o[n] = sh_valid[n][skew[n] - 3'd1];
                hs_active_o[n] = sh_hs[n][skew[n] - 3'd1];
            end
            for (int k = 0; k < 7; k++) if (3'(k) < skew[n] && sh_hs[n][k]) drain_busy = 1'b1;
        end
    end
`else
    localparam state_t TRAIL_NEXT = IDLE;
    logic skew_unused;
    assign skew_unused = ^lane_skew_i;
    assign drain_busy = 1'b0;
    assign lane_byte_o = r_byte;
    assign lane_valid_o = r_valid;
    assign hs_active_o = r_hs;
`endif
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            pre_cnt <= '0;
            for (int n = 0; n < L; n++) trail_cnt[n] <= '0;
            last_msb <= '0;
            r_byte <= '0;
            r_valid <= '0;
            r_hs <= '0;
            data_ready_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    r_byte <= '0;
                    r_valid <= '0;
                    r_hs <= '0;
                    pre_cnt <= '0;
                    if (data_valid_i) state <= PREAMBLE;
                end
                PREAMBLE: begin
                    r_byte <= '0;
                    r_valid <= '0;
                    r_hs <= '1;
                    pre_cnt <= pre_cnt + 4'd1;
                    if (pre_cnt == 4'(PREAMBLE_CYCLES - 1)) state <= SYNC;
                end
                SYNC: begin
                    for (int n = 0; n < L; n++) begin
                        r_byte[n*G +: G] <= sync_word;
                        trail_cnt[n] <= '0;
                    end
                    r_valid <= '1;
                    r_hs <= '1;
                    last_msb <= {L{sync_word[G-1]}};
                    data_ready_o <= 1'b1;
                    state <= DATA;
                end
                DATA: begin
                    r_hs <= '1;
                    if (!data_valid_i) begin
                        r_byte <= '0;
                        r_valid <= '1;
                        last_msb <= '0;
                        underrun_o <= 1'b1;
                    end else if (!data_last_i) begin
                        r_byte <= data_i;
                        r_valid <= '1;
                        for (int n = 0; n < L; n++) last_msb[n] <= data_i[n*G + G - 1];
                    end else begin
                        // unkept lanes spend this beat as their first trail beat
                        for (int n = 0; n < L; n++) begin
                            if (keep[n]) begin
                                r_byte[n*G +: G] <= data_i[n*G +: G];
                                last_msb[n] <= data_i[n*G + G - 1];
                                trail_cnt[n] <= 3'd0;
                            end else begin
                                r_byte[n*G +: G] <= {G{~last_msb[n]}};
                                trail_cnt[n] <= 3'd1;
                            end
                        end
                        r_valid <= keep;
                        data_ready_o <= 1'b0;
                        state <= TRAIL;
                    end
                end
                TRAIL: begin
                    r_valid <= '0;
                    for (int n = 0; n < L; n++) begin
                        r_byte[n*G +: G] <= trail_done[n] ? '0 : {G{~last_msb[n]}};
                        r_hs[n] <= !trail_done[n];
                        if (!trail_done[n]) trail_cnt[n] <= trail_cnt[n] + 3'd1;
                    end
                    if (&trail_done) state <= TRAIL_NEXT;
                end
                DRAIN: if (!drain_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mipi_csi_tx_lane_distributor.sv
// tb_mipi_csi_tx_lane_distributor: scoreboard bench for the CSI-2 TX lane distributor
module tb_mipi_csi_tx_lane_distributor;
    localparam int G = 16;
    localparam int L = 4;
    localparam int P = 4;
    localparam int T = 2;
    typedef struct packed {
        logic [63:0] b;
        logic [3:0]  v;
        logic [3:0]  h;
        logic        r;
    } beat_t;
    logic clk_i = 1'b0;
    logic reset_n_i = 1'b1;
    logic [63:0] data_i = '0;
    logic data_valid_i = 1'b0;
    logic data_last_i = 1'b0;
    logic [3:0] data_keep_i = '0;
    logic [11:0] lane_skew_i = '0;
    logic data_ready_o;
    logic [63:0] lane_byte_o;
    logic [3:0] lane_valid_o;
    logic [3:0] hs_active_o;
    logic underrun_o;
    beat_t exp_q[$];
    logic [63:0] words [8];
    bit bub [8];
    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    mipi_csi_tx_lane_distributor dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .data_i(data_i),
        .data_valid_i(data_valid_i),
        .data_last_i(data_last_i),
        .data_keep_i(data_keep_i),
        .data_ready_o(data_ready_o),
        .lane_skew_i(lane_skew_i),
        .lane_byte_o(lane_byte_o),
        .lane_valid_o(lane_valid_o),
        .hs_active_o(hs_active_o),
        .underrun_o(underrun_o)
    );

    // expected beats are queued as each word (or bubble) is committed, and popped once per cycle from the first HS beat
    task automatic run_packet(input int n, input logic [3:0] keep, input string tag);
        int idx, cyc;
        int c [L];
        bit started, more;
        logic [3:0] msb, k;
        beat_t e;
        idx = 0;
        cyc = 0;
        started = 0;
        msb = 4'hF;
        k = (keep == 4'h0) ? 4'hF : keep;
        for (int i = 0; i < P; i++) exp_q.push_back(beat_t'{b: '0, v: 4'h0, h: 4'hF, r: 1'b0});
        exp_q.push_back(beat_t'{b: {4{16'hB800}}, v: 4'hF, h: 4'hF, r: 1'b1});
        data_valid_i = 1'b1;
        data_i = words[0];
        data_last_i = (n == 1);
        data_keep_i = keep;
        while ((idx < n || exp_q.size() > 0) && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            if (exp_q.size() > 0 && (started || hs_active_o != 4'h0)) begin
                started = 1;
                e = exp_q.pop_front();
                total++;
                if ({lane_byte_o, lane_valid_o, hs_active_o, data_ready_o} !== e) begin
                    bad++;
                    $display("FAIL %s beat: got byte=%h valid=%h hs=%h rdy=%b, want byte=%h valid=%h hs=%h rdy=%b",
                             tag, lane_byte_o, lane_valid_o, hs_active_o, data_ready_o, e.b, e.v, e.h, e.r);
                end
            end
            if (idx < n && data_ready_o) begin
                if (bub[idx]) begin
                    data_valid_i = 1'b0;
                    msb = 4'h0;
                    exp_q.push_back(beat_t'{b: '0, v: 4'hF, h: 4'hF, r: 1'b1});
                end else begin
                    data_valid_i = 1'b1;
                    data_i = words[idx];
                    data_last_i = (idx == n - 1);
                    data_keep_i = keep;
                    e = beat_t'{b: words[idx], v: 4'hF, h: 4'hF, r: (idx != n - 1)};
                    if (idx == n - 1) begin
                        e.v = k;
                        for (int i = 0; i < L; i++) begin
                            c[i] = k[i] ? 0 : 1;
                            if (!k[i]) e.b[i*G +: G] = {G{~msb[i]}};
                        end
                    end
                    for (int i = 0; i < L; i++) if (k[i] || idx != n - 1) msb[i] = words[idx][i*G + G - 1];
                    exp_q.push_back(e);
                    if (idx == n - 1) begin
                        more = 1;
                        while (more) begin
                            more = 0;
                            e = beat_t'{b: '0, v: 4'h0, h: 4'h0, r: 1'b0};
                            for (int i = 0; i < L; i++) begin
                                if (c[i] < T) begin
                                    e.b[i*G +: G] = {G{~msb[i]}};
                                    e.h[i] = 1'b1;
                                    c[i]++;
                                    more = 1;
                                end
                            end
                            exp_q.push_back(e);
                        end
                    end
                end
                idx++;
            end else if (idx < n) begin
                data_valid_i = 1'b1;
                data_i = words[idx];
                data_last_i = (idx == n - 1);
                data_keep_i = keep;
            end else begin
                data_valid_i = 1'b0;
                data_last_i = 1'b0;
            end
        end
        total++;
        if (exp_q.size() != 0 || idx != n) begin
            bad++;
            $display("FAIL %s timeout: %0d beats unseen, %0d of %0d items sent", tag, exp_q.size(), idx, n);
        end
        exp_q.delete();
        data_valid_i = 1'b0;
        data_last_i = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset_n_i = 1'b0;
        #1;
        total++;
        if ({lane_byte_o, lane_valid_o, hs_active_o, data_ready_o, underrun_o} !== '0) begin
            bad++;
            $display("FAIL reset_values: got byte=%h valid=%h hs=%h rdy=%b und=%b, want all 0",
                     lane_byte_o, lane_valid_o, hs_active_o, data_ready_o, underrun_o);
        end
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total++;
        if (hs_active_o !== 4'h0 || data_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: got hs=%h rdy=%b, want hs=0 rdy=0", hs_active_o, data_ready_o);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) bub[i] = 0;
        words[0] = 64'h1111_1111_1111_1111;
        words[1] = 64'h2222_2222_2222_2222;
        words[2] = 64'h8000_0000_0000_0000;
        run_packet(3, 4'hF, "basic");
    endtask

    task automatic test_keep();
        words[0] = 64'h1111_9999_1111_1111;
        words[1] = 64'hAAAA_5555_8001_7FFE;
        run_packet(2, 4'b0011, "keep");
        total++;
        if (underrun_o !== 1'b0) begin
            bad++;
            $display("FAIL no_underrun: got %b, want 0", underrun_o);
        end
    endtask

    task automatic test_underrun();
        words[0] = 64'h0123_4567_89AB_CDEF;
        bub[1] = 1;
        words[2] = 64'hFEDC_BA98_7654_3210;
        run_packet(3, 4'hF, "underrun");
        bub[1] = 0;
        total++;
        if (underrun_o !== 1'b1) begin
            bad++;
            $display("FAIL underrun_set: got %b, want 1", underrun_o);
        end
    endtask

    task automatic test_back_to_back();
        words[0] = 64'h8000_0000_8000_0000;
        run_packet(1, 4'h0, "keep_zero");
        words[0] = 64'h5A5A_A5A5_0F0F_F0F0;
        words[1] = 64'hFFFF_0000_7FFF_8000;
        run_packet(2, 4'hF, "back_to_back");
        total++;
        if (underrun_o !== 1'b1) begin
            bad++;
            $display("FAIL underrun_sticky: got %b, want 1", underrun_o);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        cyc = 0;
        words[0] = 64'h1111_1111_1111_1111;
        data_i = words[0];
        data_valid_i = 1'b1;
        data_last_i = 1'b0;
        data_keep_i = 4'hF;
        while (!data_ready_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        total++;
        if (data_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_ready: got rdy=%b after %0d cycles, want 1", data_ready_o, cyc);
        end
        repeat (2) @(negedge clk_i);
        total++;
        if (hs_active_o !== 4'hF || lane_valid_o !== 4'hF) begin
            bad++;
            $display("FAIL mid_data: got hs=%h valid=%h, want F F", hs_active_o, lane_valid_o);
        end
        reset_n_i = 1'b0;
        #1;
        total++;
        if ({lane_byte_o, lane_valid_o, hs_active_o, data_ready_o, underrun_o} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got byte=%h valid=%h hs=%h rdy=%b und=%b, want all 0",
                     lane_byte_o, lane_valid_o, hs_active_o, data_ready_o, underrun_o);
        end
        data_valid_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if (hs_active_o !== 4'h0 || lane_valid_o !== 4'h0) begin
                bad++;
                $display("FAIL no_trail: got hs=%h valid=%h, want 0 0", hs_active_o, lane_valid_o);
            end
        end
        test_basic();
    endtask

`ifdef MIPI_TX_LANE_SKEW_EN
    task automatic test_skew();
        int cyc, t1, t2, taken, rdy_bad;
        bit last_done;
        cyc = 0;
        t1 = -1;
        t2 = -1;
        taken = 0;
        rdy_bad = 0;
        last_done = 0;
        lane_skew_i = {3'd1, 3'd7, 3'd0, 3'd3};
        data_i = 64'h1234_5678_9ABC_DEF0;
        data_valid_i = 1'b1;
        data_last_i = 1'b0;
        data_keep_i = 4'hF;
        while (cyc < 200 && !(last_done && hs_active_o == 4'h0)) begin
            @(negedge clk_i);
            cyc++;
            if (t1 < 0 && lane_valid_o[1]) t1 = cyc;
            if (t2 < 0 && lane_valid_o[2]) t2 = cyc;
            if (last_done && data_ready_o) rdy_bad++;
            if (data_ready_o && !last_done) begin
                data_last_i = (taken == 1);
                data_i = taken == 1 ? 64'h0F0F_F0F0_8888_7777 : 64'h1234_5678_9ABC_DEF0;
                last_done = (taken == 1);
                taken++;
            end else if (last_done) begin
                data_valid_i = 1'b0;
                data_last_i = 1'b0;
            end
        end
        total++;
        if (t2 - t1 !== 7 || t1 < 0) begin
            bad++;
            $display("FAIL skew_sync: got lane2-lane1 sync gap=%0d (t1=%0d), want 7", t2 - t1, t1);
        end
        total++;
        if (rdy_bad !== 0 || !last_done || hs_active_o !== 4'h0) begin
            bad++;
            $display("FAIL skew_drain: got %0d ready beats during drain, done=%b hs=%h, want 0 1 0",
                     rdy_bad, last_done, hs_active_o);
        end
        data_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        lane_skew_i = '0;
        repeat (2) @(negedge clk_i);
        test_basic();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_keep();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
`ifdef MIPI_TX_LANE_SKEW_EN
        test_skew();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
